// File: rtl/cfa_frame_scheduler.sv
// Frame-level sequencer for the CFA window addressing engine: config latch, launch, credit gating, drain, re-arm.
// Optional stall-cycle counter output (stallCycles_o) enabled by defining CFA_SCHED_STALL_CNT_EN.
module cfa_frame_scheduler #(
  parameter int rowBitWidth  = 11,
  parameter int colBitWidth  = 11,
  parameter int CREDIT_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cfgValid_i,
  input  logic [rowBitWidth-1:0]             cfgRows_i,
  input  logic [colBitWidth-1:0]             cfgCols_i,
  output logic                               cfgReady_o,
  input  logic                               abort_i,
  output logic                               agStart_o,
  output logic                               agEn_o,
  output logic                               agRst_o,
  output logic [rowBitWidth-1:0]             agRowMax_o,
  output logic [colBitWidth-1:0]             agColMax_o,
  input  logic                               winDone_i,
  input  logic                               winRetire_i,
  output logic                               busy_o,
  output logic                               frameDone_o,
  output logic                               cfgErr_o,
  output logic                               creditErr_o,
  output logic [rowBitWidth+colBitWidth-1:0] winCount_o
`ifdef CFA_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                        stallCycles_o
`endif
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam int PW = rowBitWidth + colBitWidth;
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_DEPTH);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, REARM, ABORT} state_t;

  state_t                 state_q;
  logic [rowBitWidth-1:0] rowMax_q;
  logic [colBitWidth-1:0] colMax_q;
  logic [PW-1:0]          target_q, winCount_q, winCount_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   creditErr_q, creditErr_d;
  logic                   agStart_q, agEn_q, agRst_q, frameDone_q, cfgErr_q;
  logic                   win_take, cfg_bad;
`ifdef CFA_SCHED_STALL_CNT_EN
  logic [15:0]            stall_q;
`endif

  assign win_take   = (state_q == RUN) && winDone_i;
  assign winCount_d = winCount_q + PW'(1);
  // Sizes are signed: a set MSB or zero is a non-positive dimension.
  assign cfg_bad    = cfgRows_i[rowBitWidth-1] || (cfgRows_i == '0) ||
                      cfgCols_i[colBitWidth-1] || (cfgCols_i == '0);

  // A window produced and a slot freed in the same cycle cancel out.
  always_comb begin
    credits_d   = credits_q;
    creditErr_d = creditErr_q;
    if (win_take && !winRetire_i) begin
      credits_d = (credits_q == '0) ? '0 : credits_q - CW'(1);
    end else if (!win_take && winRetire_i) begin
      if (credits_q == CRED_FULL) creditErr_d = 1'b1;
      else                        credits_d   = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rowMax_q    <= '0;
      colMax_q    <= '0;
      target_q    <= '0;
      winCount_q  <= '0;
      credits_q   <= CRED_FULL;
      creditErr_q <= 1'b0;
      agStart_q   <= 1'b0;
      agEn_q      <= 1'b0;
      agRst_q     <= 1'b0;
      frameDone_q <= 1'b0;
      cfgErr_q    <= 1'b0;
`ifdef CFA_SCHED_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      agStart_q   <= 1'b0;
      agEn_q      <= 1'b0;
      agRst_q     <= 1'b0;
      frameDone_q <= 1'b0;
      cfgErr_q    <= 1'b0;
      credits_q   <= credits_d;
      creditErr_q <= creditErr_d;
`ifdef CFA_SCHED_STALL_CNT_EN
      if (state_q == RUN && !agEn_q && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
`endif
      if (abort_i && state_q != IDLE && state_q != ABORT) begin
        state_q <= ABORT;
        agRst_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (cfgValid_i) begin
              if (cfg_bad) begin
                cfgErr_q <= 1'b1;
              end else begin
                rowMax_q   <= cfgRows_i;
                colMax_q   <= cfgCols_i;
                target_q   <= PW'(cfgRows_i) * PW'(cfgCols_i);
                winCount_q <= '0;
                agStart_q  <= 1'b1;
                state_q    <= LAUNCH;
`ifdef CFA_SCHED_STALL_CNT_EN
                stall_q    <= '0;
`endif
              end
            end
          end
          LAUNCH: begin
            state_q <= RUN;
            agEn_q  <= (credits_d != '0);
          end
          RUN: begin
            if (win_take) winCount_q <= winCount_d;
            if (win_take && winCount_d == target_q) state_q <= DRAIN;
            else                                    agEn_q  <= (credits_d != '0);
          end
          DRAIN: begin
            if (credits_q == CRED_FULL) begin
              state_q     <= REARM;
              agStart_q   <= 1'b1;
              frameDone_q <= 1'b1;
            end
          end
          REARM: state_q <= IDLE;
          ABORT: begin
            credits_q <= CRED_FULL;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cfgReady_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign agStart_o   = agStart_q;
  assign agEn_o      = agEn_q;
  assign agRst_o     = agRst_q;
  assign agRowMax_o  = rowMax_q;
  assign agColMax_o  = colMax_q;
  assign frameDone_o = frameDone_q;
  assign cfgErr_o    = cfgErr_q;
  assign creditErr_o = creditErr_q;
  assign winCount_o  = winCount_q;
`ifdef CFA_SCHED_STALL_CNT_EN
  assign stallCycles_o = stall_q;
`endif

endmodule
